// File: rtl/ddl_serial_gen.sv
// ddl_serial_gen: sequential binary-to-ASCII-decimal converter for the DDL/SIU
// serial number. The double-dabble engine converts one input bit per clock;
// the result is formatted into padded ASCII and latched into a holding register
// that only changes when a conversion completes.

// Per-digit shift/add-3 correction. This is applied to every BCD digit before each shift.
module ddl_dd_add3 (
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);
  assign d_out = (d_in >= 4'd5) ? d_in + 4'd3 : d_in;
endmodule

module ddl_serial_gen #(
  parameter int          BIN_W    = 8,
  parameter int          NDIG     = 4,
  parameter logic [7:0]  PAD_CHAR = 8'h30,
  parameter bit          AUTO     = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [BIN_W-1:0]    bin_in,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                valid,
  output logic                ovf,
  output logic [8*NDIG-1:0]   siusn
);
  // Internal BCD is wide enough for any BIN_W-bit value, so no digit is lost.
  // Overflow is judged on the digits above NDIG.
  localparam int ND_INT = (NDIG > (BIN_W + 2) / 3) ? NDIG : (BIN_W + 2) / 3;
  localparam int CW     = $clog2(BIN_W + 1);
  localparam int SW     = 4 * ND_INT + BIN_W;

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  state_t                  state, state_nxt;
  logic [BIN_W-1:0]        sr;
  logic [BIN_W-1:0]        last;
  logic [ND_INT-1:0][3:0]  bcd, bcd_adj;
  logic [SW-1:0]           shifted;
  logic [CW-1:0]           cnt;
  logic                    trig;
  logic                    lead;
  logic [8*NDIG-1:0]       siusn_fmt;
  logic                    ovf_fmt;

  genvar g;
  generate
    for (g = 0; g < ND_INT; g++) begin : g_dig
      ddl_dd_add3 u_add3 (.d_in(bcd[g]), .d_out(bcd_adj[g]));
    end
  endgenerate

  assign shifted = {bcd_adj, sr} << 1;

  // In AUTO mode, a conversion also starts on a fresh reset or when the input changes.
  assign trig = start | (AUTO & (~valid | (bin_in != last)));

  // Format the BCD result into ASCII. Leading zeros are padded, digit 0 always prints,
  // and any nonzero digit above NDIG raises overflow.
  always_comb begin
    lead      = 1'b1;
    siusn_fmt = '0;
    ovf_fmt   = 1'b0;
    for (int i = ND_INT - 1; i >= 0; i--) begin
      if (bcd[i] != 4'd0) lead = 1'b0;
      if (i < NDIG)
        siusn_fmt[8*i +: 8] = (lead && (i != 0)) ? PAD_CHAR : (8'h30 | {4'h0, bcd[i]});
      else if (bcd[i] != 4'd0)
        ovf_fmt = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: BIN_W shift cycles, then one format cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(BIN_W - 1)) state_nxt = FORMAT;
      FORMAT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output holding registers. done is a pulse that is cleared every cycle
  // unless the FORMAT cycle sets it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr    <= '0;
      last  <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      siusn <= {NDIG{8'h30}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (trig) begin
          sr   <= bin_in;
          last <= bin_in;
          bcd  <= '0;
          cnt  <= '0;
          busy <= 1'b1;
        end
        SHIFT: begin
          {bcd, sr} <= shifted;
          cnt       <= cnt + 1'b1;
        end
        FORMAT: begin
          siusn <= siusn_fmt;
          ovf   <= ovf_fmt;
          done  <= 1'b1;
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
